syn_fifo_wr_arb: RTL and testbench



---
 rtl/syn_fifo_wr_arb_if.sv | 29 ++
 rtl/syn_fifo_wr_arb.sv | 129 ++++++++++++
 tb/tb_syn_fifo_wr_arb.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/syn_fifo_wr_arb_if.sv
// Requester and FIFO write-side signals shared by the round-robin write arbiter.
// The arbiter connects through the slave modport; the producers and FIFO side use master.
interface syn_fifo_wr_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 18
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          fifo_full_i;
  logic                          fifo_af_i;
  logic                          fifo_wr_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic [NUM_REQ-1:0]            grant_o;
  logic [$clog2(NUM_REQ)-1:0]    grant_id_o;
  logic                          busy_o;
  logic [31:0]                   wr_count_o;

  modport master (
    output req_valid_i, req_last_i, req_data_i, fifo_full_i, fifo_af_i,
    input  req_ready_o, fifo_wr_o, fifo_data_o, grant_o, grant_id_o, busy_o, wr_count_o
  );

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, fifo_full_i, fifo_af_i,
    output req_ready_o, fifo_wr_o, fifo_data_o, grant_o, grant_id_o, busy_o, wr_count_o
  );
endinterface

// File: rtl/syn_fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers,
// one packet per grant, with a burst limit and a release on an idle producer.
module syn_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 18,
  parameter int MAX_BURST  = 8,
  parameter int IDLE_TMO   = 4,
  parameter int STOP_ON_AF = 1
) (
  input  logic               clk_wr_i,
  input  logic               rst_n_i,
  syn_fifo_wr_arb_if.slave   bus
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int TMO_W  = $clog2(IDLE_TMO + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state_q, state_nxt;
  logic [NUM_REQ-1:0]  grant_q;
  logic [ID_W-1:0]     grant_id_q;
  logic [ID_W-1:0]     ptr_q;
  logic [BEAT_W-1:0]   beat_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [31:0]         wr_count_q;

  logic                sel_found;
  logic [ID_W-1:0]     sel_idx;
  logic                stall;
  logic                g_valid;
  logic                g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                beat;
  logic                idle_cycle;
  logic                release_beat;
  logic                tmo_hit;
  logic                release_xfer;

  // Cyclic search starting just after the last winner, so the previous owner ranks last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!sel_found && bus.req_valid_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    stall        = bus.fifo_full_i | ((STOP_ON_AF != 0) & bus.fifo_af_i);
    g_valid      = bus.req_valid_i[grant_id_q];
    g_last       = bus.req_last_i[grant_id_q];
    g_data       = bus.req_data_i[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    beat         = (state_q == XFER) & g_valid & ~stall;
    idle_cycle   = (state_q == XFER) & ~g_valid & ~stall;
    release_beat = beat & (g_last | (beat_cnt_q == BEAT_W'(MAX_BURST - 1)));
    tmo_hit      = idle_cycle & (tmo_cnt_q == TMO_W'(IDLE_TMO - 1));
    release_xfer = release_beat | tmo_hit;
  end

  always_ff @(posedge clk_wr_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt       = state_q;
    bus.req_ready_o = '0;
    bus.fifo_wr_o   = 1'b0;
    bus.fifo_data_o = '0;
    bus.busy_o      = 1'b0;
    bus.grant_o     = grant_q;
    bus.grant_id_o  = grant_id_q;
    bus.wr_count_o  = wr_count_q;
    case (state_q)
      IDLE: begin
        if (sel_found) state_nxt = XFER;
      end
      XFER: begin
        bus.busy_o      = 1'b1;
        bus.req_ready_o = stall ? '0 : grant_q;
        bus.fifo_wr_o   = beat;
        bus.fifo_data_o = g_data;
        if (release_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stalled cycles clear the idle counter, so a full FIFO can never force a release.
  always_ff @(posedge clk_wr_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      wr_count_q <= '0;
    end else begin
      if (beat) wr_count_q <= wr_count_q + 32'd1;
      if (state_q == IDLE) begin
        if (sel_found) begin
          grant_q    <= NUM_REQ'(1) << sel_idx;
          grant_id_q <= sel_idx;
          ptr_q      <= sel_idx;
        end
        beat_cnt_q <= '0;
        tmo_cnt_q  <= '0;
      end else if (release_xfer) begin
        grant_q    <= '0;
        grant_id_q <= '0;
        beat_cnt_q <= '0;
        tmo_cnt_q  <= '0;
      end else if (beat) begin
        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
        tmo_cnt_q  <= '0;
      end else if (stall) begin
        tmo_cnt_q  <= '0;
      end else begin
        tmo_cnt_q  <= tmo_cnt_q + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_syn_fifo_wr_arb.sv
// Directed bench for syn_fifo_wr_arb: arbitration order, burst limit, backpressure,
// idle release and asynchronous reset, with hand-computed expected values.
module tb_syn_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 18;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  syn_fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  syn_fifo_wr_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8), .IDLE_TMO(4), .STOP_ON_AF(1)
  ) dut (
    .clk_wr_i (clk),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic l, input logic [DW-1:0] d);
    bus.req_valid_i[k] = v;
    bus.req_last_i[k]  = l;
    bus.req_data_i[k*DW +: DW] = d;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.req_last_i  = '0;
    bus.req_data_i  = '0;
    bus.fifo_full_i = 1'b0;
    bus.fifo_af_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present one word from requester k, expect it to be written this cycle, then advance.
  task automatic doBeat(input int k, input logic [DW-1:0] d, input logic l);
    applyStimulus(k, 1'b1, l, d);
    #1;
    checkOutput("beat_wr", 32'(bus.fifo_wr_o), 32'd1);
    checkOutput("beat_data", 32'(bus.fifo_data_o), 32'(d));
    checkOutput("beat_ready", 32'(bus.req_ready_o), 32'(1 << k));
    checkOutput("beat_gid", 32'(bus.grant_id_o), 32'(k));
    tick();
  endtask

  // One arbitration cycle: nothing written, nothing granted yet.
  task automatic checkBubble(input string tag);
    #1;
    checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    checkOutput({tag, "_wr"}, 32'(bus.fifo_wr_o), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.req_ready_o), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    clk = 1'b0;

    // Test 1: reset state, then a 3-beat packet from requester 2.
    doReset();
    checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("rst_grant", 32'(bus.grant_o), 32'd0);
    checkOutput("rst_count", bus.wr_count_o, 32'd0);
    applyStimulus(2, 1'b1, 1'b0, 18'h00A0);
    checkBubble("t1_arb");
    checkOutput("t1_grant", 32'(bus.grant_o), 32'b0100);
    doBeat(2, 18'h00A0, 1'b0);
    doBeat(2, 18'h00A1, 1'b0);
    doBeat(2, 18'h00A2, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t1_idle", 32'(bus.busy_o), 32'd0);
    checkOutput("t1_count", bus.wr_count_o, 32'd3);
    tick();

    // Test 2: all four requesters with single-beat packets, round-robin with bubbles.
    doReset();
    for (int k = 0; k < NR; k++) applyStimulus(k, 1'b1, 1'b1, 18'(32'h100 + k));
    for (int n = 0; n < 5; n++) begin
      checkBubble("t2_arb");
      doBeat(n % NR, 18'(32'h100 + (n % NR)), 1'b1);
    end
    for (int k = 0; k < NR; k++) applyStimulus(k, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t2_count", bus.wr_count_o, 32'd5);
    tick();

    // Test 3: requester 0 streams 20 words with no last; bursts of 8, 8, 4.
    doReset();
    for (int n = 0; n < 20; n++) begin
      applyStimulus(0, 1'b1, (n == 19), 18'(32'h200 + n));
      if (n % 8 == 0) checkBubble("t3_arb");
      doBeat(0, 18'(32'h200 + n), (n == 19));
    end
    applyStimulus(0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t3_idle", 32'(bus.busy_o), 32'd0);
    checkOutput("t3_count", bus.wr_count_o, 32'd20);
    tick();

    // Test 4: FIFO full for 5 cycles (valid low for 3 of them), then almost-full for 1.
    doReset();
    applyStimulus(1, 1'b1, 1'b0, 18'h0300);
    checkBubble("t4_arb");
    doBeat(1, 18'h0300, 1'b0);
    doBeat(1, 18'h0301, 1'b0);
    bus.fifo_full_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        bus.fifo_full_i = 1'b0;
        bus.fifo_af_i   = 1'b1;
      end
      applyStimulus(1, (c >= 3), 1'b0, 18'h0302);
      #1;
      checkOutput("t4_stall_wr", 32'(bus.fifo_wr_o), 32'd0);
      checkOutput("t4_stall_ready", 32'(bus.req_ready_o), 32'd0);
      checkOutput("t4_stall_busy", 32'(bus.busy_o), 32'd1);
      tick();
    end
    bus.fifo_af_i = 1'b0;
    doBeat(1, 18'h0302, 1'b0);
    doBeat(1, 18'h0303, 1'b0);
    doBeat(1, 18'h0304, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t4_count", bus.wr_count_o, 32'd5);
    tick();

    // Test 5: requester 1 goes quiet after one beat; released after 4 idle cycles, then 3.
    doReset();
    applyStimulus(1, 1'b1, 1'b0, 18'h0400);
    applyStimulus(3, 1'b1, 1'b1, 18'h0433);
    checkBubble("t5_arb");
    doBeat(1, 18'h0400, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0);
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("t5_tmo_busy", 32'(bus.busy_o), 32'd1);
      checkOutput("t5_tmo_wr", 32'(bus.fifo_wr_o), 32'd0);
      tick();
    end
    #1;
    checkOutput("t5_rel_count", bus.wr_count_o, 32'd1);
    checkBubble("t5_bubble");
    doBeat(3, 18'h0433, 1'b1);
    applyStimulus(3, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t5_count", bus.wr_count_o, 32'd2);
    tick();

    // Test 6: reset asserted mid-packet clears every output immediately.
    doReset();
    applyStimulus(2, 1'b1, 1'b0, 18'h0500);
    checkBubble("t6_arb");
    doBeat(2, 18'h0500, 1'b0);
    doBeat(2, 18'h0501, 1'b0);
    applyStimulus(2, 1'b1, 1'b0, 18'h0502);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_wr", 32'(bus.fifo_wr_o), 32'd0);
    checkOutput("t6_rst_data", 32'(bus.fifo_data_o), 32'd0);
    checkOutput("t6_rst_grant", 32'(bus.grant_o), 32'd0);
    checkOutput("t6_rst_gid", 32'(bus.grant_id_o), 32'd0);
    checkOutput("t6_rst_ready", 32'(bus.req_ready_o), 32'd0);
    checkOutput("t6_rst_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("t6_rst_count", bus.wr_count_o, 32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 18'h0600);
    checkBubble("t6_arb2");
    doBeat(0, 18'h0600, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, '0);
    applyStimulus(2, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t6_count", bus.wr_count_o, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
